// File: rtl/incdec_checker.sv
// Receive-side checker for paired up/down count streams: hunts, confirms, locks, flags breaks.
// Define INCDEC_CHK_PAIR_EN to also require (inc + dec) mod 2^WIDTH == 2^(WIDTH-1).
module incdec_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_inc,
    input  logic [WIDTH-1:0] i_dec,
    input  logic             i_clrErr,
    output logic [1:0]       o_state,
    output logic             o_locked,
    output logic             o_error,
    output logic [CNT_W-1:0] o_errCount
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [GW-1:0] ONE_V = GW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        CONFIRM = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    state_t           state;
    logic [GW-1:0]    good_cnt;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;

    logic          pair_ok;
    logic          seq_ok;
    logic          err_now;
    logic [GW-1:0] good_nxt;

`ifdef INCDEC_CHK_PAIR_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] pair_sum;
    assign pair_sum = i_inc + i_dec;
    assign pair_ok  = (pair_sum == HALF);
`else
    assign pair_ok = 1'b1;
`endif

    always_comb begin
        seq_ok   = (i_inc == prev_inc + 1'b1) && (i_dec == prev_dec - 1'b1);
        good_nxt = good_cnt + 1'b1;
        err_now  = i_en && (state == LOCKED) && !(pair_ok && seq_ok);
    end

    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state      <= HUNT;
            good_cnt   <= '0;
            prev_inc   <= '0;
            prev_dec   <= '0;
            o_locked   <= 1'b0;
            o_error    <= 1'b0;
            o_errCount <= '0;
        end else begin
            o_error <= 1'b0;
            if (i_en) begin
                prev_inc <= i_inc;
                prev_dec <= i_dec;
                unique case (state)
                    HUNT: begin
                        if (pair_ok) begin
                            good_cnt <= ONE_V;
                            if (LOCK_CNT == 1) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (!pair_ok) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end else if (!seq_ok) begin
                            good_cnt <= ONE_V;
                        end else begin
                            good_cnt <= good_nxt;
                            if (good_nxt == LOCK_V) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Failing sample is dropped, not reused as a lock candidate
                        if (!(pair_ok && seq_ok)) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                            o_locked <= 1'b0;
                            o_error  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        good_cnt <= '0;
                        o_locked <= 1'b0;
                    end
                endcase
            end
            if (i_clrErr) begin
                o_errCount <= '0;
            end else if (err_now && (o_errCount != CNT_MAX)) begin
                o_errCount <= o_errCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_incdec_checker.sv
// Directed plus randomized bench for incdec_checker against a behavioural reference model.
module tb_incdec_checker;

    logic       i_clk = 1'b0;
    logic       i_nReset;
    logic       i_en;
    logic [3:0] i_inc;
    logic [3:0] i_dec;
    logic       i_clrErr;
    logic [1:0] o_state;
    logic       o_locked;
    logic       o_error;
    logic [7:0] o_errCount;

    incdec_checker #(.WIDTH(4), .LOCK_CNT(3), .CNT_W(8)) dut (
        .i_clk(i_clk),
        .i_nReset(i_nReset),
        .i_en(i_en),
        .i_inc(i_inc),
        .i_dec(i_dec),
        .i_clrErr(i_clrErr),
        .o_state(o_state),
        .o_locked(o_locked),
        .o_error(o_error),
        .o_errCount(o_errCount)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: mode 0 hunt, 1 confirm, 2 locked
    int m_mode, m_good, m_pi, m_pd, m_err, m_cnt;
    int v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_pi = 0; m_pd = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model(input int en, input int inc, input int dec, input int clr);
        bit pair, seq;
        m_err = 0;
        if (en != 0) begin
`ifdef INCDEC_CHK_PAIR_EN
            pair = ((inc + dec) % 16) == 8;
`else
            pair = 1'b1;
`endif
            seq = (inc == (m_pi + 1) % 16) && (dec == (m_pd + 15) % 16);
            if (m_mode == 0) begin
                if (pair) begin
                    m_good = 1;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (!pair) begin
                    m_mode = 0;
                    m_good = 0;
                end else if (!seq) begin
                    m_good = 1;
                end else begin
                    m_good++;
                    if (m_good == 3) m_mode = 2;
                end
            end else begin
                if (!(pair && seq)) begin
                    m_mode = 0;
                    m_good = 0;
                    m_err = 1;
                end
            end
            m_pi = inc;
            m_pd = dec;
        end
        if (clr != 0) m_cnt = 0;
        else if (m_err != 0 && m_cnt < 255) m_cnt++;
    endtask

    task automatic step(input int en, input int inc, input int dec, input int clr);
        i_en = en[0];
        i_inc = inc[3:0];
        i_dec = dec[3:0];
        i_clrErr = clr[0];
        @(posedge i_clk);
        #1;
        model(en, inc % 16, dec % 16, clr);
        chk("state", o_state, m_mode);
        chk("locked", o_locked, (m_mode == 2));
        chk("error", o_error, m_err);
        chk("errcount", o_errCount, m_cnt);
    endtask

    task automatic good(input int clr);
        step(1, v, (24 - v) % 16, clr);
        v = (v + 1) % 16;
    endtask

    task automatic brk(input int clr);
        step(1, (v + 1) % 16, (24 - v) % 16, clr);
        v = (v + 2) % 16;
    endtask

    task automatic relock();
        for (int i = 0; i < 8 && m_mode != 2; i++) good(0);
        chk("relock", o_locked, 1);
    endtask

    initial begin
        i_nReset = 1'b0;
        i_en = 1'b0;
        i_inc = '0;
        i_dec = '0;
        i_clrErr = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_state", o_state, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_error", o_error, 0);
        chk("rst_cnt", o_errCount, 0);
        i_nReset = 1'b1;

        // lock onto inc 4,5,6 / dec 4,3,2
        v = 4;
        good(0);
        chk("s1_state", o_state, 1);
        good(0);
        chk("s2_state", o_state, 1);
        good(0);
        chk("s3_state", o_state, 2);
        chk("s3_locked", o_locked, 1);

        // run through both bus wraps
        for (int i = 0; i < 14; i++) good(0);
        chk("wrap_locked", o_locked, 1);
        chk("wrap_cnt", o_errCount, 0);

        // single skipped value on inc
        brk(0);
        chk("brk_error", o_error, 1);
        chk("brk_cnt", o_errCount, 1);
        chk("brk_state", o_state, 0);
        chk("brk_locked", o_locked, 0);
        good(0);
        chk("brk_pulse_end", o_error, 0);
        good(0);
        good(0);
        chk("relock3", o_locked, 1);

        // inc off-pair in hunt
        brk(0);
        step(1, 3, (24 - v) % 16, 0);
`ifdef INCDEC_CHK_PAIR_EN
        chk("pair_hunt", o_state, 0);
`else
        chk("pair_hunt", o_state, 1);
`endif
        v = (v + 1) % 16;
        relock();

        // enable low with frozen buses
        for (int i = 0; i < 5; i++) step(0, i_inc, i_dec, 0);
        good(0);
        good(0);
        chk("en_locked", o_locked, 1);
        chk("en_cnt", o_errCount, 2);

        // saturate error counter
        for (int k = 0; k < 258; k++) begin
            brk(0);
            relock();
        end
        chk("sat_cnt", o_errCount, 8'hFF);

        // clear wins over simultaneous error
        brk(1);
        chk("clr_error", o_error, 1);
        chk("clr_cnt", o_errCount, 0);
        relock();

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 9);
            c = ($urandom_range(0, 15) == 0) ? 1 : 0;
            if (r == 0) step(0, $urandom_range(0, 15), $urandom_range(0, 15), c);
            else if (r == 1) step(1, $urandom_range(0, 15), $urandom_range(0, 15), c);
            else if (r == 2) brk(c);
            else good(c);
        end

        // asynchronous reset mid-lock
        relock();
        @(posedge i_clk);
        #3;
        i_nReset = 1'b0;
        #1;
        model_reset();
        chk("arst_state", o_state, 0);
        chk("arst_locked", o_locked, 0);
        chk("arst_error", o_error, 0);
        chk("arst_cnt", o_errCount, 0);
        @(posedge i_clk);
        #1;
        i_nReset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/incdec_checker.md
# incdec_checker

Receive-side checker for the paired up/down count streams produced by the team's increment/decrement counter. Samples both buses on enabled cycles, locks to the sequence, then flags any break in it. Maintains a saturating error count for bring-up and the BIST status register. Sits downstream of the counter, in the same clock domain.

## Interface
- WIDTH, 4, bit width of each count bus (>= 2)
- LOCK_CNT, 3, consecutive good samples required to declare lock (>= 1)
- CNT_W, 8, width of the error counter
- i_clk  in  1  clock; all logic on rising edge
- i_nReset  in  1  asynchronous, active-low reset
- i_en  in  1  sample enable; i_inc/i_dec are evaluated only when high
- i_inc  in  WIDTH  incrementing count stream
- i_dec  in  WIDTH  decrementing count stream
- i_clrErr  in  1  synchronous clear of o_errCount
- o_state  out  2  00 HUNT, 01 CONFIRM, 10 LOCKED (11 unused)
- o_locked  out  1  high while state is LOCKED
- o_error  out  1  one-cycle pulse on a sequence break detected in LOCKED
- o_errCount  out  CNT_W  saturating count of o_error pulses

## Operation
- Pair check P: (i_inc + i_dec) mod 2^WIDTH == 2^(WIDTH-1). With INCDEC_CHK_PAIR_EN undefined, P is always true.
- Sequence check S: i_inc == prev_inc + 1 and i_dec == prev_dec - 1, both mod 2^WIDTH. Wrap-around is legal: inc 0xF -> 0x0 and dec 0x0 -> 0xF pass for WIDTH=4.
- prev_inc/prev_dec are loaded from i_inc/i_dec on every enabled sample, in every state.
- Disabled cycles (i_en=0) change nothing: no state change, no good-count update, no error.
- good_cnt is sized to hold LOCK_CNT.
- HUNT:
  - sample with P true -> good_cnt=1; go to LOCKED if LOCK_CNT==1, else CONFIRM.
  - sample with P false -> stay in HUNT.
- CONFIRM:
  - sample with P and S -> good_cnt+1; go to LOCKED when good_cnt+1 == LOCK_CNT.
  - sample with P true but S false -> restart: good_cnt=1, stay in CONFIRM. No error.
  - sample with P false -> HUNT. No error.
- LOCKED:
  - sample with P and S -> stay.
  - any failure -> o_error pulse, o_errCount+1, go to HUNT. good_cnt=0, so the failing sample is not reused as a lock candidate.
- o_errCount saturates at 2^CNT_W-1.
- i_clrErr has priority: if a clear and an error occur in the same cycle, o_errCount becomes 0.

## Timing
- All outputs are registered. Each reflects the sample taken on the previous rising edge: one cycle of latency.
- o_locked rises the cycle after the LOCK_CNT-th consecutive good sample. o_locked falls in the same cycle that o_error pulses.
- o_error is high for exactly one cycle per detected break. Back-to-back breaks cannot occur, because the checker must re-lock first.
- Reset (asynchronous assert, synchronous release):
  - o_state=HUNT, o_locked=0, o_error=0, o_errCount=0.
  - good_cnt=0, prev_inc=0, prev_dec=0.
- Reset asserted mid-lock clears everything immediately. No error is counted.

## Configuration
- INCDEC_CHK_PAIR_EN defined: the P check is compiled in. The bus pair must also satisfy the fixed sum relation, so a single corrupted bus is caught even if the other bus is corrupted to match its own sequence.
- INCDEC_CHK_PAIR_EN undefined: the sum adder is removed and P is tied true. Only per-bus sequence continuity is checked, and HUNT locks onto any first sample.

## Test plan
- Reset, then the WIDTH=4 generator stream: inc 4,5,6…, dec 4,3,2…, i_en=1 -> o_state 00,01,01,10. o_locked=1 in the cycle after the 3rd sample. o_errCount=0.
- Locked stream run through the wrap (inc 0xE,0xF,0x0; dec 0x2,0x1,0x0,0xF) -> o_locked stays high and o_error never pulses.
- Locked, then inject inc=0x9 where 0x8 is expected -> a one-cycle o_error pulse, o_errCount=1, o_state=00. Resume the good stream -> relock after 3 samples.
- With the macro defined, hold dec correct and drive inc=0x3 in HUNT -> state stays 00. With the macro undefined, the same stimulus moves the state to 01.
- i_en low for 5 cycles mid-lock with the buses frozen, then continue the stream -> no error and o_locked stays high. Then force 2^CNT_W+2 breaks -> o_errCount saturates at 0xFF.
- Pulse i_clrErr in the same cycle as a break -> o_errCount=0 and o_error still pulses. Assert i_nReset low mid-lock -> all outputs are 0 asynchronously.
